// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One digit slot per REFRESH_DIV cycles; data updates land only on frame boundaries.
module display_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    lz_en,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_done,
  output logic [N_DIGITS-1:0]     an,
  output logic [3:0]              bcd_out,
  output logic                    dp_n
);

  localparam int CW     = $clog2(REFRESH_DIV);
  localparam int IW     = $clog2(N_DIGITS);
  localparam int ON_LEN = REFRESH_DIV - GUARD;

  typedef enum logic {S_ON, S_GUARD} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*N_DIGITS-1:0]   disp_val, disp_val_nxt;
  logic [N_DIGITS-1:0]     disp_dp, disp_dp_nxt;
  logic [4*N_DIGITS-1:0]   pend_val, pend_val_nxt;
  logic [N_DIGITS-1:0]     pend_dp, pend_dp_nxt;
  logic                    pend_flag, pend_flag_nxt;
  logic                    load_ack_nxt, frame_done_nxt;
  logic [N_DIGITS-1:0]     an_nxt;
  logic [3:0]              bcd_nxt;
  logic                    dp_n_nxt;
  logic [N_DIGITS-1:0]     blank;
  logic                    zero_above;
  logic                    boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_GUARD;
      cnt        <= '0;
      idx        <= IW'(N_DIGITS - 1);
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
      an         <= '1;
      bcd_out    <= '0;
      dp_n       <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      disp_val   <= disp_val_nxt;
      disp_dp    <= disp_dp_nxt;
      pend_val   <= pend_val_nxt;
      pend_dp    <= pend_dp_nxt;
      pend_flag  <= pend_flag_nxt;
      load_ack   <= load_ack_nxt;
      frame_done <= frame_done_nxt;
      an         <= an_nxt;
      bcd_out    <= bcd_nxt;
      dp_n       <= dp_n_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + CW'(1);
    idx_nxt        = idx;
    disp_val_nxt   = disp_val;
    disp_dp_nxt    = disp_dp;
    pend_val_nxt   = pend_val;
    pend_dp_nxt    = pend_dp;
    pend_flag_nxt  = pend_flag;
    load_ack_nxt   = 1'b0;
    frame_done_nxt = 1'b0;
    an_nxt         = an;
    bcd_nxt        = bcd_out;
    dp_n_nxt       = dp_n;
    blank          = '0;
    zero_above     = 1'b1;
    boundary       = 1'b0;

    case (state)
      S_ON: begin
        if (cnt == CW'(ON_LEN - 1)) begin
          state_nxt = S_GUARD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (cnt == CW'(GUARD - 1)) begin
          state_nxt = S_ON;
          cnt_nxt   = '0;
          boundary  = (idx == IW'(N_DIGITS - 1));
          idx_nxt   = boundary ? '0 : idx + IW'(1);
        end
      end
    endcase

    // A load on the boundary edge bypasses the pending registers entirely
    if (boundary) begin
      frame_done_nxt = 1'b1;
      if (load) begin
        disp_val_nxt  = value_in;
        disp_dp_nxt   = dp_in;
        pend_flag_nxt = 1'b0;
        load_ack_nxt  = 1'b1;
      end else if (pend_flag) begin
        disp_val_nxt  = pend_val;
        disp_dp_nxt   = pend_dp;
        pend_flag_nxt = 1'b0;
        load_ack_nxt  = 1'b1;
      end
    end else if (load) begin
      pend_val_nxt  = value_in;
      pend_dp_nxt   = dp_in;
      pend_flag_nxt = 1'b1;
    end

    // Walk from the most significant digit down; digit 0 always lights
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_val_nxt[4*i +: 4] == 4'd0);
      blank[i]   = lz_en && (i > 0) && zero_above;
    end

    if (state_nxt == S_ON) begin
      an_nxt   = blank[idx_nxt] ? '1 : ~(N_DIGITS'(1) << idx_nxt);
      bcd_nxt  = disp_val_nxt[4*idx_nxt +: 4];
      dp_n_nxt = ~(disp_dp_nxt[idx_nxt] & ~blank[idx_nxt]);
    end else begin
      an_nxt = '1;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-position reference model.
module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int G     = 2;
  localparam int FRAME = N * RD;
  localparam int ONL   = RD - G;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic        load_ack, frame_done;
  logic [3:0]  an;
  logic [3:0]  bcd_out;
  logic        dp_n;

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;

  // Reference model: k counts clock edges since reset release
  int          k;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dpd, m_pdp;
  bit          m_flag;
  logic [3:0]  e_an, e_bcd;
  logic        e_dp, e_ack, e_fd;

  display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .lz_en(lz_en),
    .load(load), .load_ack(load_ack), .frame_done(frame_done), .an(an),
    .bcd_out(bcd_out), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; m_disp = '0; m_pend = '0; m_dpd = '0; m_pdp = '0; m_flag = 0;
    e_an = 4'hF; e_bcd = 4'h0; e_dp = 1'b1; e_ack = 1'b0; e_fd = 1'b0;
  endtask

  task automatic model_edge();
    int p, d;
    bit bnd, blk;
    logic [15:0] sh;
    k++;
    bnd = (k >= G) && ((k - G) % FRAME == 0);
    e_ack = 1'b0;
    e_fd  = bnd;
    if (bnd) begin
      if (load) begin
        m_disp = value_in; m_dpd = dp_in; m_flag = 0; e_ack = 1'b1;
      end else if (m_flag) begin
        m_disp = m_pend; m_dpd = m_pdp; m_flag = 0; e_ack = 1'b1;
      end
    end else if (load) begin
      m_pend = value_in; m_pdp = dp_in; m_flag = 1;
    end
    if (k < G) begin
      e_an = 4'hF;
    end else begin
      p = (k - G) % FRAME;
      d = p / RD;
      if (p % RD < ONL) begin
        sh    = m_disp >> (4 * d);
        blk   = lz_en && (d > 0) && (sh == 16'h0);
        e_an  = blk ? 4'hF : ~(4'b0001 << d);
        e_bcd = sh[3:0];
        e_dp  = blk ? 1'b1 : ~m_dpd[d];
      end else begin
        e_an = 4'hF;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    if (load_ack === 1'b1) ack_seen++;
    check("an", an, e_an);
    check("bcd_out", bcd_out, e_bcd);
    check("dp_n", dp_n, e_dp);
    check("load_ack", load_ack, e_ack);
    check("frame_done", frame_done, e_fd);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value_in = v; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0; value_in = 16'($urandom);
  endtask

  // Advance until the next clock edge is a frame boundary
  task automatic to_pre_boundary();
    int n;
    n = 0;
    while (((k + 1 - G) % FRAME != 0) || (k + 1 < G)) begin
      step();
      n++;
      if (n > 2 * FRAME) begin
        check("pre_boundary_timeout", n, 0);
        break;
      end
    end
  endtask

  initial begin
    int a0, n;
    logic [15:0] rv;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an, 4'hF);
    check("rst_bcd", bcd_out, 4'h0);
    check("rst_dp", dp_n, 1'b1);
    check("rst_ack", load_ack, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Free run from reset: digit 0 lights after the first guard
    step();
    check("guard_after_rst", an, 4'hF);
    step();
    check("first_on", an, 4'hE);
    check("first_fd", frame_done, 1'b1);
    run(2 * FRAME + 3);

    // Mid-frame load waits for the boundary
    run(5);
    do_load(16'h1234, 4'b0010);
    run(FRAME + 6);

    // Leading-zero blanking, dp suppressed on blanked digits
    lz_en = 1'b1;
    do_load(16'h0050, 4'b1100);
    run(2 * FRAME);
    do_load(16'h0000, 4'b1111);
    run(2 * FRAME);
    lz_en = 1'b0;

    // Latest pending load wins, one ack per commit
    to_pre_boundary();
    run(4);
    a0 = ack_seen;
    do_load(16'h1111, 4'b0001);
    run(3);
    do_load(16'h2222, 4'b0000);
    run(FRAME);
    check("single_ack", ack_seen - a0, 1);

    // Load exactly on the boundary edge commits in the same frame
    to_pre_boundary();
    do_load(16'h9876, 4'b0100);
    check("bnd_ack", load_ack, 1'b1);
    check("bnd_digit0", bcd_out, 4'h6);
    run(5);
    do_load(16'hF9F0, 4'b0000);
    run(2 * FRAME);

    // Async reset during digit 2 with a load pending
    to_pre_boundary();
    run(3);
    do_load(16'hA5A5, 4'b1010);
    n = 0;
    while ((k - G) % FRAME != 2 * RD + 1 && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("digit2_on", an, 4'hB);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_an", an, 4'hF);
    check("async_bcd", bcd_out, 4'h0);
    check("async_dp", dp_n, 1'b1);
    check("async_fd", frame_done, 1'b0);
    run(2);
    @(negedge clk) rst_n = 1'b1;
    a0 = ack_seen;
    run(2 * FRAME + 4);
    check("no_ack_after_rst", ack_seen - a0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lz_en = 1'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++)
        rv[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      value_in = rv;
      dp_in    = 4'($urandom);
      load     = ($urandom_range(0, 19) == 0);
      step();
    end
    load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
